ddr3_wr_oe_sched: RTL and testbench



---
 rtl/ddr3_wr_pkg.sv | 26 ++
 rtl/ddr3_slot_sched.sv | 29 ++
 rtl/ddr3_wr_oe_sched.sv | 161 ++++++++++++++++
 tb/tb_ddr3_wr_oe_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_wr_pkg.sv
// Shared constants and helpers for the DDR3 write output-enable scheduler.
// Slot numbering: one SCLK cycle carries two ECLK slots (T0 = even, T1 = odd).
package ddr3_wr_pkg;

  localparam int          SLOTS_PER_CYCLE = 2;
  localparam int          MAX_WL_DEF      = 16;
  localparam int          SCHED_DEPTH     = 2 * MAX_WL_DEF + 8;

  localparam int unsigned PREAMBLE_SLOTS  = 1;
  localparam int unsigned POSTAMBLE_SLOTS = 1;
  localparam int unsigned BURST_SLOTS     = 4;
  localparam int unsigned DQS_SLOTS       = PREAMBLE_SLOTS + BURST_SLOTS + POSTAMBLE_SLOTS;
  localparam int unsigned LVL_SLOTS       = 2;

  // Contiguous run of n ones starting at bit off.
  function automatic logic [SCHED_DEPTH-1:0] slot_mask(input int unsigned off,
                                                       input int unsigned n);
    logic [SCHED_DEPTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SCHED_DEPTH; i++) begin
      m[i] = (i >= off) && (i < off + n);
    end
    return m;
  endfunction

endpackage

// File: rtl/ddr3_slot_sched.sv
// One slot schedule: shifts down by one SCLK cycle (two slots) every clock and
// ORs in newly scheduled slots. Exposes the two slots of the current cycle.
module ddr3_slot_sched
  import ddr3_wr_pkg::*;
#(
  parameter int DEPTH = SCHED_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] i_load,
  output logic [1:0]       o_slots,
  output logic             o_any
);

  logic [DEPTH-1:0] r_sched;

  // Advance the schedule by one cycle and merge in the new reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sched <= '0;
    end else begin
      r_sched <= {{SLOTS_PER_CYCLE{1'b0}}, r_sched[DEPTH-1:SLOTS_PER_CYCLE]} | i_load;
    end
  end

  assign o_slots = r_sched[1:0];
  assign o_any   = |r_sched;

endmodule

// File: rtl/ddr3_wr_oe_sched.sv
// DDR3 write-path output-enable scheduler for x2-geared DQS/DQ tristate cells.
// Accepts BL8 bursts, reserves preamble/data/postamble slots at the sampled
// write latency and flags the SCLK cycles (and starting phase) carrying data.
// Optional write-leveling support is compiled in with `define WR_LEVELING_EN.
module ddr3_wr_oe_sched
  import ddr3_wr_pkg::*;
#(
  parameter int MAX_WL = MAX_WL_DEF,
  parameter int DEPTH  = 2 * MAX_WL + 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(MAX_WL+1)-1:0] wl_eclk,
  input  logic                        wr_req,
  output logic                        wr_ack,
  output logic                        dqs_t0,
  output logic                        dqs_t1,
  output logic                        dq_t0,
  output logic                        dq_t1,
  output logic                        wr_data_en,
  output logic                        wr_data_phase,
  output logic                        busy
`ifdef WR_LEVELING_EN
  ,
  input  logic                        lvl_mode,
  input  logic                        lvl_pulse
`endif
);

  localparam int WL_W = $clog2(MAX_WL + 1);

  logic [WL_W-1:0]  w_wl;
  int unsigned      w_s;
  logic [1:0]       r_gap_cnt;
  logic [1:0]       w_gap_cnt;
  logic             w_lvl_mode;
  logic             w_lvl_fire;
  logic [DEPTH-1:0] w_dqs_load;
  logic [DEPTH-1:0] w_dq_load;
  logic [DEPTH-1:0] w_dat_load;
  logic [1:0]       w_dqs;
  logic [1:0]       w_dq;
  logic [1:0]       w_dat;
  logic             w_dqs_any;
  logic             w_dq_any;
  logic             w_dat_any;
  logic             w_data_en;
  logic             w_first;
  logic             w_phase;
  logic             r_prev_t1;
  logic             r_phase;

  // Clamp the requested latency into the supported 2..MAX_WL window.
  always_comb begin
    w_wl = wl_eclk;
    if (wl_eclk < WL_W'(2)) begin
      w_wl = WL_W'(2);
    end else if (wl_eclk > WL_W'(MAX_WL)) begin
      w_wl = WL_W'(MAX_WL);
    end
  end

  assign w_s = 32'(w_wl);

`ifdef WR_LEVELING_EN
  assign w_lvl_mode = lvl_mode;
  assign w_lvl_fire = lvl_pulse & ~w_dqs_any;
`else
  assign w_lvl_mode = 1'b0;
  assign w_lvl_fire = 1'b0;
`endif

  // w_gap_cnt includes the current cycle, so the second cycle after an
  // accept is eligible again: BL8 bursts can run seamlessly.
  assign w_gap_cnt = (r_gap_cnt == 2'd2) ? 2'd2 : r_gap_cnt + 2'd1;
  assign wr_ack    = wr_req & (w_gap_cnt >= 2'd2) & rst_n & ~w_lvl_mode;

  // Spacing counter: cleared on accept, otherwise counts up and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if (wr_ack) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= w_gap_cnt;
    end
  end

  // Slot reservations for an accepted burst and for a leveling strobe.
  always_comb begin
    w_dqs_load = '0;
    w_dq_load  = '0;
    w_dat_load = '0;
    if (wr_ack) begin
      w_dqs_load = DEPTH'(slot_mask(w_s - PREAMBLE_SLOTS, DQS_SLOTS));
      w_dq_load  = DEPTH'(slot_mask(w_s, BURST_SLOTS));
      w_dat_load = w_dq_load;
    end
    if (w_lvl_fire) begin
      w_dqs_load = w_dqs_load | DEPTH'(slot_mask(w_s, LVL_SLOTS));
    end
  end

  ddr3_slot_sched #(.DEPTH(DEPTH)) u_dqs_oe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_dqs_load),
    .o_slots (w_dqs),
    .o_any   (w_dqs_any)
  );

  ddr3_slot_sched #(.DEPTH(DEPTH)) u_dq_oe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_dq_load),
    .o_slots (w_dq),
    .o_any   (w_dq_any)
  );

  ddr3_slot_sched #(.DEPTH(DEPTH)) u_dat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_dat_load),
    .o_slots (w_dat),
    .o_any   (w_dat_any)
  );

  assign dqs_t0 = ~w_dqs[0];
  assign dqs_t1 = ~w_dqs[1];
  assign dq_t0  = ~w_dq[0];
  assign dq_t1  = ~w_dq[1];
  assign busy   = w_dqs_any;

  // A data cycle whose predecessor ended without data in T1 opens a burst;
  // the phase is taken there and held while the burst continues.
  assign w_data_en     = w_dat[0] | w_dat[1];
  assign w_first       = w_data_en & ~r_prev_t1;
  assign w_phase       = w_first ? (w_dat[1] & ~w_dat[0]) : r_phase;
  assign wr_data_en    = w_data_en;
  assign wr_data_phase = w_data_en & w_phase;

  // Remember last T1 data slot and the phase latched for the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_t1 <= 1'b0;
      r_phase   <= 1'b0;
    end else begin
      r_prev_t1 <= w_dat[1];
      if (w_first) begin
        r_phase <= w_phase;
      end
    end
  end

  a_wl_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_ack |-> (wl_eclk >= WL_W'(2) && wl_eclk <= WL_W'(MAX_WL)));

  a_dq_in_dqs: assert property (@(posedge clk) disable iff (!rst_n)
    (w_dq_any | w_dat_any) |-> w_dqs_any);

endmodule

// File: tb/tb_ddr3_wr_oe_sched.sv
// Directed bench for ddr3_wr_oe_sched. Slot k of a captured run belongs to
// SCLK cycle k/2 counted from the first cycle after the first accept.
module tb_ddr3_wr_oe_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wl_eclk;
  logic       wr_req;
  logic       wr_ack;
  logic       dqs_t0, dqs_t1, dq_t0, dq_t1;
  logic       wr_data_en, wr_data_phase, busy;
`ifdef WR_LEVELING_EN
  logic        lvl_mode;
  logic        lvl_pulse;
  logic [31:0] lvl_plan;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] cap_dqs, cap_dq, cap_en, cap_ph, cap_busy, cap_ack;

  always #5 clk = ~clk;

  ddr3_wr_oe_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wl_eclk       (wl_eclk),
    .wr_req        (wr_req),
    .wr_ack        (wr_ack),
    .dqs_t0        (dqs_t0),
    .dqs_t1        (dqs_t1),
    .dq_t0         (dq_t0),
    .dq_t1         (dq_t1),
    .wr_data_en    (wr_data_en),
    .wr_data_phase (wr_data_phase),
    .busy          (busy)
`ifdef WR_LEVELING_EN
    ,
    .lvl_mode      (lvl_mode),
    .lvl_pulse     (lvl_pulse)
`endif
  );

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive wr_req per cycle from req_plan (cycle 0 = first request cycle),
  // wl0 in cycle 0 and wl1 afterwards; record acks per request cycle and
  // outputs per post-accept cycle.
  task automatic capture(input int ncyc, input logic [31:0] req_plan,
                         input logic [4:0] wl0, input logic [4:0] wl1);
    cap_dqs = '0; cap_dq = '0; cap_en = '0; cap_ph = '0; cap_busy = '0; cap_ack = '0;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      wr_req  = req_plan[j];
      wl_eclk = (j == 0) ? wl0 : wl1;
`ifdef WR_LEVELING_EN
      lvl_pulse = lvl_plan[j];
`endif
      #1;
      cap_ack[j] = wr_ack;
      if (j >= 1) begin
        cap_dqs[2*(j-1)]   = ~dqs_t0;
        cap_dqs[2*(j-1)+1] = ~dqs_t1;
        cap_dq[2*(j-1)]    = ~dq_t0;
        cap_dq[2*(j-1)+1]  = ~dq_t1;
        cap_en[j-1]        = wr_data_en;
        cap_ph[j-1]        = wr_data_en & wr_data_phase;
        cap_busy[j-1]      = busy;
      end
    end
    wr_req = 1'b0;
`ifdef WR_LEVELING_EN
    lvl_pulse = 1'b0;
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wl_eclk = 5'd6;
`ifdef WR_LEVELING_EN
    lvl_mode  = 1'b0;
    lvl_pulse = 1'b0;
    lvl_plan  = '0;
`endif

    // Reset state, with a request pending during reset
    idle(2);
    wr_req = 1'b1;
    #1;
    chk("rst_tristates", 64'({dqs_t0, dqs_t1, dq_t0, dq_t1}), 64'hF);
    chk("rst_ack", 64'(wr_ack), 64'h0);
    chk("rst_data_en", 64'(wr_data_en), 64'h0);
    chk("rst_phase", 64'(wr_data_phase), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single burst, even latency
    capture(12, 32'h1, 5'd6, 5'd6);
    chk("wl6_ack", cap_ack, rng(0, 0));
    chk("wl6_dqs", cap_dqs, rng(5, 10));
    chk("wl6_dq", cap_dq, rng(6, 9));
    chk("wl6_en", cap_en, rng(3, 4));
    chk("wl6_phase", cap_ph, 64'h0);
    chk("wl6_busy", cap_busy, rng(0, 5));
    idle(2);

    // Single burst, odd latency: three data cycles, phase 1
    capture(12, 32'h1, 5'd7, 5'd7);
    chk("wl7_dqs", cap_dqs, rng(6, 11));
    chk("wl7_dq", cap_dq, rng(7, 10));
    chk("wl7_en", cap_en, rng(3, 5));
    chk("wl7_phase", cap_ph, rng(3, 5));
    chk("wl7_busy", cap_busy, rng(0, 5));
    idle(2);

    // Minimum latency
    capture(8, 32'h1, 5'd2, 5'd2);
    chk("wl2_dqs", cap_dqs, rng(1, 6));
    chk("wl2_dq", cap_dq, rng(2, 5));
    chk("wl2_en", cap_en, rng(1, 2));
    chk("wl2_busy", cap_busy, rng(0, 3));
    idle(2);

    // Maximum latency
    capture(16, 32'h1, 5'd16, 5'd16);
    chk("wl16_dqs", cap_dqs, rng(15, 20));
    chk("wl16_dq", cap_dq, rng(16, 19));
    chk("wl16_en", cap_en, rng(8, 9));
    chk("wl16_busy", cap_busy, rng(0, 10));
    idle(2);

    // Request held continuously: seamless bursts every two cycles
    capture(16, 32'h1F, 5'd6, 5'd6);
    chk("seam_ack", cap_ack, rng(0, 0) | rng(2, 2) | rng(4, 4));
    chk("seam_dqs", cap_dqs, rng(5, 18));
    chk("seam_dq", cap_dq, rng(6, 17));
    chk("seam_en", cap_en, rng(3, 8));
    chk("seam_phase", cap_ph, 64'h0);
    chk("seam_busy", cap_busy, rng(0, 9));
    idle(2);

    // Requests at cycles 0 and 3: DQS postamble/preamble merge
    capture(14, 32'h9, 5'd6, 5'd6);
    chk("gap_ack", cap_ack, rng(0, 0) | rng(3, 3));
    chk("gap_dqs", cap_dqs, rng(5, 16));
    chk("gap_dq", cap_dq, rng(6, 9) | rng(12, 15));
    chk("gap_en", cap_en, rng(3, 4) | rng(6, 7));
    chk("gap_phase", cap_ph, 64'h0);
    idle(2);

    // Request at cycle 1 is held until cycle 2
    capture(12, 32'h7, 5'd6, 5'd6);
    chk("hold_ack", cap_ack, rng(0, 0) | rng(2, 2));
    chk("hold_dqs", cap_dqs, rng(5, 14));
    idle(2);

    // Latency changed while busy: first burst keeps its latency
    capture(14, 32'h5, 5'd6, 5'd9);
    chk("wlchg_ack", cap_ack, rng(0, 0) | rng(2, 2));
    chk("wlchg_dqs", cap_dqs, rng(5, 10) | rng(12, 17));
    chk("wlchg_dq", cap_dq, rng(6, 9) | rng(13, 16));
    chk("wlchg_en", cap_en, rng(3, 4) | rng(6, 8));
    chk("wlchg_phase", cap_ph, rng(6, 8));
    idle(2);

    // Reset asserted mid-burst
    wl_eclk = 5'd6;
    wr_req  = 1'b1;
    @(posedge clk);
    #1 wr_req = 1'b0;
    idle(4);
    chk("mid_pre_tristates", 64'({dqs_t0, dqs_t1, dq_t0, dq_t1}), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tristates", 64'({dqs_t0, dqs_t1, dq_t0, dq_t1}), 64'hF);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_en", 64'(wr_data_en), 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    capture(12, 32'h1, 5'd6, 5'd6);
    chk("post_rst_dqs", cap_dqs, rng(5, 10));
    chk("post_rst_dq", cap_dq, rng(6, 9));
    chk("post_rst_en", cap_en, rng(3, 4));
    idle(2);

`ifdef WR_LEVELING_EN
    // Leveling strobe: DQS only, write requests blocked
    lvl_mode = 1'b1;
    lvl_plan = 32'h1;
    capture(8, 32'hFF, 5'd4, 5'd4);
    chk("lvl_ack", cap_ack, 64'h0);
    chk("lvl_dqs", cap_dqs, rng(4, 5));
    chk("lvl_dq", cap_dq, 64'h0);
    chk("lvl_en", cap_en, 64'h0);
    lvl_mode = 1'b0;
    lvl_plan = '0;
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
